// File: rtl/loader_pkg.sv
// Shared types and default protocol bytes for the UART program loader.
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_RESP   = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } loader_state_t;

   localparam logic [7:0] DEF_SYNC = 8'hAA;
   localparam logic [7:0] DEF_ACK  = 8'h06;
   localparam logic [7:0] DEF_NAK  = 8'h15;

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes in MSB-first; o_done flags the byte that completes a word,
// with o_word presenting that completed word in the same cycle.
module byte_packer #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_clr,
   input  logic              i_valid,
   input  logic [7:0]        i_byte,
   output logic [WORD_W-1:0] o_word,
   output logic              o_done
);

   localparam int BYTES = WORD_W / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   logic [WORD_W-1:0] r_word;
   logic [IDX_W-1:0]  r_idx;

   assign o_word = (r_word << 4'd8) | WORD_W'(i_byte);
   assign o_done = i_valid && (r_idx == LAST_IDX);

   // Byte accumulator and position within the current word.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_word <= {WORD_W{1'b0}};
         r_idx  <= {IDX_W{1'b0}};
      end else if (i_clr) begin
         r_word <= {WORD_W{1'b0}};
         r_idx  <= {IDX_W{1'b0}};
      end else if (i_valid) begin
         r_word <= o_word;
         r_idx  <= o_done ? {IDX_W{1'b0}} : r_idx + IDX_ONE;
      end else begin
         r_word <= r_word;
         r_idx  <= r_idx;
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: sync byte, optional length, big-endian words to instruction memory,
// XOR checksum, then ACK/NAK over UART and a done/err level to release the core.
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int         WORD_W    = 32,
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC,
   parameter int         LEN_MODE  = 0,
   parameter logic [7:0] ACK_BYTE  = DEF_ACK,
   parameter logic [7:0] NAK_BYTE  = DEF_NAK
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        rx_data,
   input  logic              rx_ready,
   input  logic              ferr,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [16:0]     DEPTH_L = 17'(DEPTH_C);

   loader_state_t     r_state;
   logic [15:0]       r_len;
   logic [7:0]        r_csum;
   logic [ADDR_W:0]   r_count;
   logic              r_ack;
   logic [7:0]        r_tx_data;
   logic              r_tx_start;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [WORD_W-1:0] r_mem_wdata;
   logic              r_done;
   logic              r_err;

   logic              w_start;
   logic              w_pk_valid;
   logic [WORD_W-1:0] w_word;
   logic              w_word_done;
   logic [15:0]       w_len;
   logic [ADDR_W:0]   w_count_nx;
   logic              w_last_word;

   assign w_start = rx_ready && (rx_data == SYNC_BYTE) &&
                    ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
   assign w_pk_valid  = rx_ready && !ferr && (r_state == ST_DATA);
   assign w_len       = {r_len[15:8], rx_data};
   assign w_count_nx  = r_count + ONE_C;
   assign w_last_word = (LEN_MODE == 0) ? (w_word == {WORD_W{1'b0}})
                                        : (17'(w_count_nx) == {1'b0, r_len});

   byte_packer #(.WORD_W(WORD_W)) u_packer (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_start),
      .i_valid (w_pk_valid),
      .i_byte  (rx_data),
      .o_word  (w_word),
      .o_done  (w_word_done)
   );

   // Load sequencer with word counter, checksum and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_len       <= 16'd0;
         r_csum      <= 8'd0;
         r_count     <= {(ADDR_W+1){1'b0}};
         r_ack       <= 1'b0;
         r_tx_data   <= 8'd0;
         r_tx_start  <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {ADDR_W{1'b0}};
         r_mem_wdata <= {WORD_W{1'b0}};
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_mem_we   <= 1'b0;
         r_tx_start <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (w_start) begin
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_count <= {(ADDR_W+1){1'b0}};
                  r_csum  <= 8'd0;
                  r_state <= (LEN_MODE != 0) ? ST_LEN_HI : ST_DATA;
               end
            end
            ST_LEN_HI: begin
               if (ferr) begin
                  r_ack   <= 1'b0;
                  r_state <= ST_RESP;
               end else if (rx_ready) begin
                  r_len[15:8] <= rx_data;
                  r_state     <= ST_LEN_LO;
               end
            end
            ST_LEN_LO: begin
               if (ferr) begin
                  r_ack   <= 1'b0;
                  r_state <= ST_RESP;
               end else if (rx_ready) begin
                  r_len <= w_len;
                  if ({1'b0, w_len} > DEPTH_L) begin
                     r_ack   <= 1'b0;
                     r_state <= ST_RESP;
                  end else if (w_len == 16'd0) begin
                     r_state <= ST_CSUM;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (ferr) begin
                  r_ack   <= 1'b0;
                  r_state <= ST_RESP;
               end else if (rx_ready) begin
                  r_csum <= r_csum ^ rx_data;
                  // A word completing with the memory already full is dropped, so address 0 is never rewritten.
                  if (w_word_done) begin
                     if (r_count == DEPTH_C) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_RESP;
                     end else begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_count[ADDR_W-1:0];
                        r_mem_wdata <= w_word;
                        r_count     <= w_count_nx;
                        if (w_last_word) begin
                           r_state <= ST_CSUM;
                        end
                     end
                  end
               end
            end
            ST_CSUM: begin
               if (ferr) begin
                  r_ack   <= 1'b0;
                  r_state <= ST_RESP;
               end else if (rx_ready) begin
                  r_ack   <= (rx_data == r_csum);
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (r_tx_start) begin
                  r_done  <= r_ack;
                  r_err   <= !r_ack;
                  r_state <= r_ack ? ST_DONE : ST_ERR;
               end else if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_tx_data  <= r_ack ? ACK_BYTE : NAK_BYTE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign tx_data    = r_tx_data;
   assign tx_start   = r_tx_start;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign word_count = r_count;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench: three loader instances (length/terminator modes, small depth).
module tb_uart_prog_loader;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  rx_data [3];
   logic        rx_ready [3];
   logic        ferr [3];
   logic        tx_busy [3];
   logic [7:0]  tx_data [3];
   logic        tx_start [3];
   logic        mem_we [3];
   logic [31:0] mem_wdata [3];
   logic        done [3];
   logic        err [3];
   logic [7:0]  mem_addr0;
   logic [1:0]  mem_addr1, mem_addr2;
   logic [8:0]  wc0;
   logic [2:0]  wc1, wc2;

   int          wr_cnt [3] = '{0, 0, 0};
   int          tx_cnt [3] = '{0, 0, 0};
   logic [7:0]  tx_last [3];
   logic [31:0] last_wdata [3];
   logic [31:0] m0 [0:255];
   int          n_chk = 0;
   int          n_err = 0;
   int          base;

   always #5 clk = ~clk;

   uart_prog_loader #(.ADDR_W(8), .LEN_MODE(0)) u0 (
      .clk(clk), .rstn(rstn), .rx_data(rx_data[0]), .rx_ready(rx_ready[0]), .ferr(ferr[0]),
      .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]), .mem_we(mem_we[0]),
      .mem_addr(mem_addr0), .mem_wdata(mem_wdata[0]), .word_count(wc0), .done(done[0]), .err(err[0]));

   uart_prog_loader #(.ADDR_W(2), .LEN_MODE(1)) u1 (
      .clk(clk), .rstn(rstn), .rx_data(rx_data[1]), .rx_ready(rx_ready[1]), .ferr(ferr[1]),
      .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]), .mem_we(mem_we[1]),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata[1]), .word_count(wc1), .done(done[1]), .err(err[1]));

   uart_prog_loader #(.ADDR_W(2), .LEN_MODE(0)) u2 (
      .clk(clk), .rstn(rstn), .rx_data(rx_data[2]), .rx_ready(rx_ready[2]), .ferr(ferr[2]),
      .tx_data(tx_data[2]), .tx_start(tx_start[2]), .tx_busy(tx_busy[2]), .mem_we(mem_we[2]),
      .mem_addr(mem_addr2), .mem_wdata(mem_wdata[2]), .word_count(wc2), .done(done[2]), .err(err[2]));

   // Record memory writes and UART transmissions of every instance.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (mem_we[k]) begin
            wr_cnt[k]     <= wr_cnt[k] + 1;
            last_wdata[k] <= mem_wdata[k];
         end
         if (tx_start[k]) begin
            tx_cnt[k]  <= tx_cnt[k] + 1;
            tx_last[k] <= tx_data[k];
         end
      end
      if (mem_we[0]) m0[mem_addr0] <= mem_wdata[0];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input int k, input logic [7:0] b);
      @(negedge clk);
      rx_data[k]  = b;
      rx_ready[k] = 1'b1;
      @(negedge clk);
      rx_ready[k] = 1'b0;
   endtask

   task automatic wait_resp(input int k);
      for (int i = 0; i < 300 && !(done[k] || err[k]); i++) @(negedge clk);
      chk("resp_timeout", 64'(done[k] | err[k]), 64'd1);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         rx_data[k] = 8'h00; rx_ready[k] = 1'b0; ferr[k] = 1'b0; tx_busy[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst_done", 64'(done[0]), 64'd0);
      chk("rst_err", 64'(err[0]), 64'd0);
      chk("rst_mem_we", 64'(mem_we[0]), 64'd0);
      chk("rst_tx_start", 64'(tx_start[0]), 64'd0);
      chk("rst_word_count", 64'(wc0), 64'd0);
      rstn = 1'b1;

      // Zero-terminated image with good checksum
      send_byte(0, 8'hAA);
      send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
      chk("w0_we", 64'(mem_we[0]), 64'd1);
      chk("w0_addr", 64'(mem_addr0), 64'd0);
      chk("w0_data", 64'(mem_wdata[0]), 64'h01020304);
      chk("w0_count", 64'(wc0), 64'd1);
      for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
      chk("w1_addr", 64'(mem_addr0), 64'd1);
      chk("w1_data", 64'(mem_wdata[0]), 64'h0);
      send_byte(0, 8'h04);
      wait_resp(0);
      chk("t1_done", 64'(done[0]), 64'd1);
      chk("t1_err", 64'(err[0]), 64'd0);
      chk("t1_count", 64'(wc0), 64'd2);
      chk("t1_wr_cnt", 64'(wr_cnt[0]), 64'd2);
      chk("t1_tx", 64'(tx_last[0]), 64'h06);
      chk("t1_tx_cnt", 64'(tx_cnt[0]), 64'd1);
      chk("t1_m0", 64'(m0[0]), 64'h01020304);

      // Length-prefixed, two words, wrong checksum (true value 0x88)
      send_byte(1, 8'hAA); send_byte(1, 8'h00); send_byte(1, 8'h02);
      send_byte(1, 8'h11); send_byte(1, 8'h22); send_byte(1, 8'h33); send_byte(1, 8'h44);
      send_byte(1, 8'h55); send_byte(1, 8'h66); send_byte(1, 8'h77); send_byte(1, 8'h88);
      send_byte(1, 8'h00);
      wait_resp(1);
      chk("t2_wr_cnt", 64'(wr_cnt[1]), 64'd2);
      chk("t2_err", 64'(err[1]), 64'd1);
      chk("t2_done", 64'(done[1]), 64'd0);
      chk("t2_tx", 64'(tx_last[1]), 64'h15);
      chk("t2_count", 64'(wc1), 64'd2);

      // Length larger than depth
      send_byte(1, 8'hAA);
      chk("t3_err_clr", 64'(err[1]), 64'd0);
      send_byte(1, 8'h00); send_byte(1, 8'h05);
      wait_resp(1);
      chk("t3_wr_cnt", 64'(wr_cnt[1]), 64'd2);
      chk("t3_err", 64'(err[1]), 64'd1);
      chk("t3_tx_cnt", 64'(tx_cnt[1]), 64'd2);
      chk("t3_tx", 64'(tx_last[1]), 64'h15);
      chk("t3_count", 64'(wc1), 64'd0);

      // Overflow: five non-zero words into a four-word memory
      send_byte(2, 8'hAA);
      for (int i = 1; i <= 20; i++) send_byte(2, 8'(i));
      wait_resp(2);
      chk("t4_wr_cnt", 64'(wr_cnt[2]), 64'd4);
      chk("t4_last", 64'(last_wdata[2]), 64'h0D0E0F10);
      chk("t4_err", 64'(err[2]), 64'd1);
      chk("t4_tx", 64'(tx_last[2]), 64'h15);
      chk("t4_count", 64'(wc2), 64'd4);

      // Framing error mid-word, then recovery
      send_byte(0, 8'hAA); send_byte(0, 8'h12); send_byte(0, 8'h34);
      @(negedge clk); ferr[0] = 1'b1;
      @(negedge clk); ferr[0] = 1'b0;
      wait_resp(0);
      chk("t5_err", 64'(err[0]), 64'd1);
      chk("t5_done", 64'(done[0]), 64'd0);
      chk("t5_tx", 64'(tx_last[0]), 64'h15);
      send_byte(0, 8'hAA);
      chk("t5_err_clr", 64'(err[0]), 64'd0);
      send_byte(0, 8'h0A); send_byte(0, 8'h0B); send_byte(0, 8'h0C); send_byte(0, 8'h0D);
      for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
      send_byte(0, 8'h00);
      wait_resp(0);
      chk("t5b_done", 64'(done[0]), 64'd1);
      chk("t5b_err", 64'(err[0]), 64'd0);
      chk("t5b_count", 64'(wc0), 64'd2);
      chk("t5b_m0", 64'(m0[0]), 64'h0A0B0C0D);

      // UART busy while a response is pending
      send_byte(0, 8'hAA);
      for (int i = 0; i < 4; i++) send_byte(0, 8'h00);
      tx_busy[0] = 1'b1;
      base = tx_cnt[0];
      send_byte(0, 8'h00);
      repeat (50) @(negedge clk);
      chk("t6_hold", 64'(tx_cnt[0]), 64'(base));
      chk("t6_hold_done", 64'(done[0]), 64'd0);
      tx_busy[0] = 1'b0;
      wait_resp(0);
      chk("t6_single", 64'(tx_cnt[0]), 64'(base + 1));
      chk("t6_done", 64'(done[0]), 64'd1);
      chk("t6_tx", 64'(tx_last[0]), 64'h06);

      // Asynchronous reset in the middle of a word
      send_byte(0, 8'hAA);
      send_byte(0, 8'h01); send_byte(0, 8'h02); send_byte(0, 8'h03); send_byte(0, 8'h04);
      send_byte(0, 8'h05);
      chk("t7_pre_count", 64'(wc0), 64'd1);
      #3 rstn = 1'b0;
      #1;
      chk("t7_count", 64'(wc0), 64'd0);
      chk("t7_wdata", 64'(mem_wdata[0]), 64'd0);
      chk("t7_tx_data", 64'(tx_data[0]), 64'd0);
      chk("t7_done", 64'(done[0]), 64'd0);
      chk("t7_err", 64'(err[0]), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
